st_unit: RTL and testbench

//  Store (write) side of the data-memory interface, complementing the existing load path.

---
 rtl/y_risc_pkg.sv | 19 +
 rtl/st_fifo.sv | 72 +++++++
 rtl/st_unit.sv | 175 +++++++++++++++++
 tb/tb_st_unit.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/y_risc_pkg.sv
// Shared types and constants for the store path of the data-memory interface.
package y_risc_pkg;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    typedef struct packed {
        logic [29:0] waddr;
        logic [31:0] data;
        logic [3:0]  be;
    } st_entry_t;

    typedef enum logic {
        ST_IDLE,
        ST_REQ
    } st_state_e;

endpackage

// File: rtl/st_fifo.sv
// Circular store buffer; exposes every slot plus a valid mask for load-hazard compares.
module st_fifo
    import y_risc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    push_i,
    input  logic                    pop_i,
    input  st_entry_t               wdata_i,
    output st_entry_t               head_o,
    output st_entry_t               next_o,
    output st_entry_t               entries_o [DEPTH],
    output logic [DEPTH-1:0]        valid_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [$clog2(DEPTH):0]  count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_idx, rd_idx, rd_nxt_idx;
    logic          do_push, do_pop;
    st_entry_t     mem_q [DEPTH];

    assign wr_idx     = wr_ptr_q[AW-1:0];
    assign rd_idx     = rd_ptr_q[AW-1:0];
    assign rd_nxt_idx = rd_idx + AW'(1);

    // Pointers carry one extra MSB so equal indices distinguish full from empty.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; valid_o masks every stale slot.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_idx] <= wdata_i;
    end

    assign head_o = mem_q[rd_idx];
    assign next_o = mem_q[rd_nxt_idx];

    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        assign entries_o[g] = mem_q[g];
        assign valid_o[g]   = {1'b0, AW'(AW'(g) - rd_idx)} < count_o;
    end

endmodule

// File: rtl/st_unit.sv
// Store unit: effective address and lane alignment, store buffer, req/ack drain FSM,
// and load-hit detection against buffered stores.
module st_unit
    import y_risc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       st_en_i,
    output logic                       st_ready_o,
    input  logic [2:0]                 funct3_i,
    input  logic [11:0]                offset_i,
    input  logic [XLEN-1:0]            rs1_data_i,
    input  logic [XLEN-1:0]            rs2_data_i,
    output logic                       mem_wr_en_o,
    output logic [XLEN-1:0]            mem_wr_addr_o,
    output logic [XLEN-1:0]            mem_wr_data_o,
    output logic [3:0]                 mem_wr_be_o,
    input  logic                       mem_wr_ack_i,
    input  logic [XLEN-1:0]            ld_addr_i,
    output logic                       ld_hit_o,
    output logic                       misalign_o,
    output logic                       illegal_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    logic [XLEN-1:0] ea;
    logic [1:0]      lane;
    logic            is_legal, is_aligned, accept, push, pop;
    logic [3:0]      st_be;
    logic [31:0]     st_data;
    st_entry_t       new_entry, head, next_head, load_e;
    st_entry_t       entries [DEPTH];
    logic [DEPTH-1:0] valid;
    logic            full, empty, load;
    logic            unused_ld_lsb;

    st_state_e       state_q, state_d;
    logic            en_q, en_d;
    logic [XLEN-1:0] addr_q, addr_d, data_q, data_d;
    logic [3:0]      be_q, be_d;
    logic            misalign_q, misalign_d, illegal_q, illegal_d;

    always_comb begin
        ea         = rs1_data_i + {{(XLEN-12){offset_i[11]}}, offset_i};
        lane       = ea[1:0];
        is_legal   = 1'b1;
        is_aligned = 1'b1;
        st_be      = '0;
        st_data    = '0;
        case (funct3_i)
            F3_SB: begin
                st_be   = 4'b0001 << lane;
                st_data = {4{rs2_data_i[7:0]}};
            end
            F3_SH: begin
                is_aligned = !lane[0];
                st_be      = 4'b0011 << lane;
                st_data    = {2{rs2_data_i[15:0]}};
            end
            F3_SW: begin
                is_aligned = (lane == 2'b00);
                st_be      = 4'b1111;
                st_data    = rs2_data_i;
            end
            default: is_legal = 1'b0;
        endcase
    end

    assign accept     = st_en_i && st_ready_o;
    assign push       = accept && is_legal && is_aligned;
    assign misalign_d = accept && is_legal && !is_aligned;
    assign illegal_d  = accept && !is_legal;
    assign new_entry  = '{waddr: ea[31:2], data: st_data, be: st_be};

    st_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push_i    (push),
        .pop_i     (pop),
        .wdata_i   (new_entry),
        .head_o    (head),
        .next_o    (next_head),
        .entries_o (entries),
        .valid_o   (valid),
        .full_o    (full),
        .empty_o   (empty),
        .count_o   (count_o)
    );

    assign st_ready_o = !full;

    // On an ack the following entry is loaded straight away: either the slot behind the
    // head, or the store being pushed this same cycle when the head was the last one.
    always_comb begin
        state_d = state_q;
        en_d    = en_q;
        addr_d  = addr_q;
        data_d  = data_q;
        be_d    = be_q;
        pop     = 1'b0;
        load    = 1'b0;
        load_e  = head;
        case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    state_d = ST_REQ;
                    en_d    = 1'b1;
                    load    = 1'b1;
                end
            end
            ST_REQ: begin
                if (mem_wr_ack_i) begin
                    pop = 1'b1;
                    if (count_o > 1) begin
                        load   = 1'b1;
                        load_e = next_head;
                    end else if (push) begin
                        load   = 1'b1;
                        load_e = new_entry;
                    end else begin
                        state_d = ST_IDLE;
                        en_d    = 1'b0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (load) begin
            addr_d = {load_e.waddr, 2'b00};
            data_d = load_e.data;
            be_d   = load_e.be;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            en_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            be_q       <= '0;
            misalign_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            en_q       <= en_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            be_q       <= be_d;
            misalign_q <= misalign_d;
            illegal_q  <= illegal_d;
        end
    end

    assign mem_wr_en_o   = en_q;
    assign mem_wr_addr_o = addr_q;
    assign mem_wr_data_o = data_q;
    assign mem_wr_be_o   = be_q;
    assign misalign_o    = misalign_q;
    assign illegal_o     = illegal_q;

    // Word-granular hazard compare; byte lanes within the word are ignored.
    always_comb begin
        ld_hit_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && (entries[i].waddr == ld_addr_i[31:2])) ld_hit_o = 1'b1;
        end
    end

    assign unused_ld_lsb = ^ld_addr_i[1:0];

endmodule

// File: tb/tb_st_unit.sv
// Self-checking bench for st_unit: directed scenarios plus randomized traffic against
// a queue-based reference model of the store buffer.
module tb_st_unit;
    import y_risc_pkg::*;

    localparam int DEPTH = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        st_en_i, st_ready_o;
    logic [2:0]  funct3_i;
    logic [11:0] offset_i;
    logic [31:0] rs1_data_i, rs2_data_i;
    logic        mem_wr_en_o;
    logic [31:0] mem_wr_addr_o, mem_wr_data_o;
    logic [3:0]  mem_wr_be_o;
    logic        mem_wr_ack_i;
    logic [31:0] ld_addr_i;
    logic        ld_hit_o, misalign_o, illegal_o;
    logic [2:0]  count_o;

    always #5 clk_i = ~clk_i;

    st_unit #(.DEPTH(DEPTH), .XLEN(32)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .st_en_i       (st_en_i),
        .st_ready_o    (st_ready_o),
        .funct3_i      (funct3_i),
        .offset_i      (offset_i),
        .rs1_data_i    (rs1_data_i),
        .rs2_data_i    (rs2_data_i),
        .mem_wr_en_o   (mem_wr_en_o),
        .mem_wr_addr_o (mem_wr_addr_o),
        .mem_wr_data_o (mem_wr_data_o),
        .mem_wr_be_o   (mem_wr_be_o),
        .mem_wr_ack_i  (mem_wr_ack_i),
        .ld_addr_i     (ld_addr_i),
        .ld_hit_o      (ld_hit_o),
        .misalign_o    (misalign_o),
        .illegal_o     (illegal_o),
        .count_o       (count_o)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } wr_t;

    wr_t         exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          stall    = 0;
    logic        pend_mis = 1'b0;
    logic        pend_ill = 1'b0;
    logic        d_en = 1'b0, d_ack = 1'b0;
    logic [2:0]  d_f3 = 3'b000;
    logic [11:0] d_off = '0;
    logic [31:0] d_rs1 = '0, d_rs2 = '0, d_ld = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference store semantics: byte size, natural alignment, shifted mask, replicated data.
    function automatic void ref_store(input logic [2:0] f3, input logic [31:0] rs1,
                                      input logic [11:0] off, input logic [31:0] rs2,
                                      output bit legal, output bit aligned, output wr_t w);
        int          size;
        int          lane;
        logic [31:0] ea;
        ea    = rs1 + 32'($signed(off));
        legal = 1'b1;
        case (f3)
            3'b000:  size = 1;
            3'b001:  size = 2;
            3'b010:  size = 4;
            default: begin size = 1; legal = 1'b0; end
        endcase
        aligned = (ea % size) == 0;
        lane    = int'(ea % 4);
        w.addr  = ea & 32'hFFFF_FFFC;
        w.be    = 4'(((1 << size) - 1) << lane);
        case (size)
            1:       w.data = 32'(rs2[7:0]) * 32'h0101_0101;
            2:       w.data = 32'(rs2[15:0]) * 32'h0001_0001;
            default: w.data = rs2;
        endcase
    endfunction

    function automatic bit model_hit(input logic [31:0] ld);
        foreach (exp_q[i]) if (exp_q[i].addr[31:2] == ld[31:2]) return 1'b1;
        return 1'b0;
    endfunction

    // One clock cycle: drive inputs at the falling edge, check, then advance the model.
    task automatic tick();
        bit   legal, aligned, ready_m;
        wr_t  w;
        @(negedge clk_i);
        st_en_i      = d_en;
        funct3_i     = d_f3;
        offset_i     = d_off;
        rs1_data_i   = d_rs1;
        rs2_data_i   = d_rs2;
        mem_wr_ack_i = d_ack;
        ld_addr_i    = d_ld;
        #1;
        ready_m = exp_q.size() < DEPTH;
        check("count", 32'(count_o), 32'(exp_q.size()));
        check("ready", 32'(st_ready_o), 32'(ready_m));
        check("ld_hit", 32'(ld_hit_o), 32'(model_hit(d_ld)));
        check("misalign", 32'(misalign_o), 32'(pend_mis));
        check("illegal", 32'(illegal_o), 32'(pend_ill));
        if (exp_q.size() != 0 && !mem_wr_en_o) stall++;
        else stall = 0;
        if (stall > 1) check("wr_stall", 32'(mem_wr_en_o), 32'd1);
        if (mem_wr_en_o) begin
            if (exp_q.size() == 0) begin
                check("wr_spurious", 32'(mem_wr_en_o), 32'd0);
            end else begin
                check("wr_addr", mem_wr_addr_o, exp_q[0].addr);
                check("wr_data", mem_wr_data_o, exp_q[0].data);
                check("wr_be", 32'(mem_wr_be_o), 32'(exp_q[0].be));
                if (d_ack) void'(exp_q.pop_front());
            end
        end
        pend_mis = 1'b0;
        pend_ill = 1'b0;
        if (d_en && ready_m) begin
            ref_store(d_f3, d_rs1, d_off, d_rs2, legal, aligned, w);
            if (!legal)        pend_ill = 1'b1;
            else if (!aligned) pend_mis = 1'b1;
            else               exp_q.push_back(w);
        end
    endtask

    task automatic do_store(input logic [2:0] f3, input logic [31:0] rs1,
                            input logic [11:0] off, input logic [31:0] rs2);
        d_en  = 1'b1;
        d_f3  = f3;
        d_rs1 = rs1;
        d_off = off;
        d_rs2 = rs2;
        tick();
        d_en = 1'b0;
    endtask

    initial begin
        st_en_i = 1'b0; funct3_i = '0; offset_i = '0; rs1_data_i = '0; rs2_data_i = '0;
        mem_wr_ack_i = 1'b0; ld_addr_i = '0;
        rst_i = 1'b0;
        #1 rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        #1;
        check("rst_count", 32'(count_o), 32'd0);
        check("rst_ready", 32'(st_ready_o), 32'd1);
        check("rst_wr_en", 32'(mem_wr_en_o), 32'd0);
        check("rst_addr", mem_wr_addr_o, 32'd0);
        check("rst_data", mem_wr_data_o, 32'd0);
        check("rst_be", 32'(mem_wr_be_o), 32'd0);
        check("rst_misalign", 32'(misalign_o), 32'd0);
        check("rst_illegal", 32'(illegal_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;

        // SB into an empty buffer: write request appears on the 2nd edge after accept.
        d_ack = 1'b1;
        do_store(F3_SB, 32'h0000_1000, 12'd3, 32'h0000_00AB);
        tick();
        check("sb_lat_en0", 32'(mem_wr_en_o), 32'd0);
        tick();
        check("sb_en", 32'(mem_wr_en_o), 32'd1);
        check("sb_addr", mem_wr_addr_o, 32'h0000_1000);
        check("sb_be", 32'(mem_wr_be_o), 32'b1000);
        check("sb_data", mem_wr_data_o, 32'hABAB_ABAB);
        tick();
        check("sb_done", 32'(mem_wr_en_o), 32'd0);

        // SH with a negative offset.
        do_store(F3_SH, 32'h0000_2000, 12'hFFE, 32'h0000_1234);
        tick();
        tick();
        check("sh_addr", mem_wr_addr_o, 32'h0000_1FFC);
        check("sh_be", 32'(mem_wr_be_o), 32'b1100);
        check("sh_data", mem_wr_data_o, 32'h1234_1234);
        tick();

        // Misaligned SW is dropped with a single-cycle pulse.
        do_store(F3_SW, 32'h0000_2002, 12'd0, 32'hDEAD_BEEF);
        tick();
        check("sw_mis_pulse", 32'(misalign_o), 32'd1);
        check("sw_mis_count", 32'(count_o), 32'd0);
        tick();
        check("sw_mis_clear", 32'(misalign_o), 32'd0);

        // Fill with ack held low, then drain four writes back to back.
        d_ack = 1'b0;
        for (int i = 0; i < 5; i++) do_store(F3_SW, 32'h0000_4000 + 32'(4 * i), 12'd0, 32'hA0 + 32'(i));
        tick();
        check("fill_ready", 32'(st_ready_o), 32'd0);
        check("fill_count", 32'(count_o), 32'd4);
        check("fill_hold_addr", mem_wr_addr_o, 32'h0000_4000);
        d_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("drain_en", 32'(mem_wr_en_o), 32'd1);
            check("drain_addr", mem_wr_addr_o, 32'h0000_4000 + 32'(4 * i));
            check("drain_data", mem_wr_data_o, 32'hA0 + 32'(i));
        end
        tick();
        check("drain_idle", 32'(mem_wr_en_o), 32'd0);
        check("drain_ready", 32'(st_ready_o), 32'd1);

        // Load hazard against a pending word.
        d_ack = 1'b0;
        do_store(F3_SW, 32'h0000_3004, 12'd0, 32'h0000_0055);
        d_ld = 32'h0000_3006;
        tick();
        check("haz_hit", 32'(ld_hit_o), 32'd1);
        d_ld = 32'h0000_3008;
        tick();
        check("haz_other_word", 32'(ld_hit_o), 32'd0);
        d_ack = 1'b1;
        d_ld  = 32'h0000_3006;
        tick();
        tick();
        check("haz_after_ack", 32'(ld_hit_o), 32'd0);

        // Address wrap and illegal funct3.
        do_store(F3_SW, 32'hFFFF_FFFC, 12'd8, 32'hCAFE_F00D);
        tick();
        tick();
        check("wrap_addr", mem_wr_addr_o, 32'h0000_0004);
        check("wrap_be", 32'(mem_wr_be_o), 32'b1111);
        tick();
        do_store(3'b011, 32'h0000_0100, 12'd0, 32'h0000_0001);
        tick();
        check("ill_pulse", 32'(illegal_o), 32'd1);
        check("ill_no_write", 32'(mem_wr_en_o), 32'd0);
        tick();
        check("ill_clear", 32'(illegal_o), 32'd0);

        // Randomized traffic in a narrow address window so load hits are frequent.
        for (int n = 0; n < 400; n++) begin
            int r;
            r     = int'($urandom_range(0, 7));
            d_en  = 1'($urandom_range(0, 1));
            d_f3  = (r < 6) ? 3'(r % 3) : 3'($urandom_range(3, 7));
            d_rs1 = 32'h0000_0100 + 32'($urandom_range(0, 63));
            d_off = 12'(int'($urandom_range(0, 32)) - 16);
            d_rs2 = $urandom;
            d_ack = ($urandom_range(0, 3) != 0);
            d_ld  = 32'h0000_00F0 + 32'($urandom_range(0, 127));
            tick();
        end
        d_en  = 1'b0;
        d_ack = 1'b1;
        repeat (8) tick();
        check("rand_drained", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of a stalled write with three entries queued.
        d_ack = 1'b0;
        for (int i = 0; i < 3; i++) do_store(F3_SW, 32'h0000_6000 + 32'(4 * i), 12'd0, 32'h600 + 32'(i));
        tick();
        check("pre_rst_en", 32'(mem_wr_en_o), 32'd1);
        @(negedge clk_i);
        #2 rst_i = 1'b1;
        #1;
        check("mid_rst_en", 32'(mem_wr_en_o), 32'd0);
        check("mid_rst_count", 32'(count_o), 32'd0);
        check("mid_rst_ready", 32'(st_ready_o), 32'd1);
        exp_q.delete();
        pend_mis = 1'b0;
        pend_ill = 1'b0;
        stall    = 0;
        @(negedge clk_i);
        rst_i = 1'b0;
        d_ack = 1'b1;
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
